// File: rtl/aui_am_lock_rx.sv
// aui_am_lock_rx: per-lane alignment-marker lock, AM stripping and payload forwarding.
// Define AM_ERR_CNT_EN to add the saturating o_am_err_cnt output.
module aui_am_lock_rx #(
   parameter int                          DATA_WIDTH   = 64,
   parameter logic [2*DATA_WIDTH-1:0]     AM_PATTERN   = 128'h9A4A26B665B5D9D9_FE8E0C260171F355,
   parameter int                          AM_PERIOD    = 20,
   parameter int                          LOCK_COUNT   = 3,
   parameter int                          UNLOCK_COUNT = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_am_lock,
   output logic                  o_am_seen,
   output logic                  o_am_err
`ifdef AM_ERR_CNT_EN
   ,
   output logic [15:0]           o_am_err_cnt
`endif
);
   localparam logic [1:0] SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2;
   localparam int PW = $clog2(AM_PERIOD + 2);
   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(UNLOCK_COUNT + 1);
   localparam logic [PW-1:0] P_A = PW'(AM_PERIOD);
   localparam logic [PW-1:0] P_B = PW'(AM_PERIOD + 1);
   localparam logic [GW-1:0] LC = GW'(LOCK_COUNT);
   localparam logic [BW-1:0] UC = BW'(UNLOCK_COUNT);
   localparam logic [DATA_WIDTH-1:0] AM_A = AM_PATTERN[2*DATA_WIDTH-1:DATA_WIDTH];
   localparam logic [DATA_WIDTH-1:0] AM_B = AM_PATTERN[DATA_WIDTH-1:0];

   logic [1:0]            state_q, state_d;
   logic [PW-1:0]         pos_q, pos_d;
   logic [GW-1:0]         good_cnt_q, good_d;
   logic [BW-1:0]         bad_cnt_q, bad_d;
   logic [DATA_WIDTH-1:0] prev_word_q, data_q;
   logic                  valid_q, lock_q, seen_q, err_q;
   logic                  match, at_b, fwd;

   always_comb begin
      match = prev_word_q == AM_A && i_data == AM_B;
      at_b = i_valid && state_q != SEARCH && pos_q == P_B;
      fwd = i_valid && state_q == LOCKED && pos_q < P_A;
      state_d = state_q;
      pos_d = pos_q;
      good_d = good_cnt_q;
      bad_d = bad_cnt_q;
      if (i_valid && state_q == SEARCH) begin
         pos_d = '0;
         if (match) begin
            state_d = LOCK_COUNT == 1 ? LOCKED : VERIFY;
            good_d = GW'(1);
         end
      end else if (i_valid) begin
         pos_d = pos_q == P_B ? '0 : pos_q + PW'(1);
         if (at_b && state_q == VERIFY) begin
            good_d = match ? good_cnt_q + GW'(1) : '0;
            state_d = !match ? SEARCH : good_cnt_q + GW'(1) == LC ? LOCKED : VERIFY;
         end
         if (at_b && state_q == LOCKED) begin
            bad_d = match ? '0 : bad_cnt_q + BW'(1);
            // Lock is lost only on the UNLOCK_COUNT-th consecutive bad marker.
            if (!match && bad_cnt_q + BW'(1) == UC) begin
               state_d = SEARCH;
               bad_d = '0;
               good_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SEARCH;
         pos_q <= '0;
         good_cnt_q <= '0;
         bad_cnt_q <= '0;
         prev_word_q <= '0;
         data_q <= '0;
         valid_q <= 1'b0;
         lock_q <= 1'b0;
         seen_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q <= pos_d;
         good_cnt_q <= good_d;
         bad_cnt_q <= bad_d;
         prev_word_q <= i_valid ? i_data : prev_word_q;
         data_q <= fwd ? i_data : data_q;
         valid_q <= fwd;
         lock_q <= state_d == LOCKED;
         seen_q <= at_b && match;
         err_q <= at_b && !match;
      end
   end

   assign o_data = data_q;
   assign o_valid = valid_q;
   assign o_am_lock = lock_q;
   assign o_am_seen = seen_q;
   assign o_am_err = err_q;

`ifdef AM_ERR_CNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_cnt_q <= '0;
      else err_cnt_q <= at_b && !match && err_cnt_q != 16'hFFFF ? err_cnt_q + 16'd1 : err_cnt_q;
   end

   assign o_am_err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_aui_am_lock_rx.sv
// tb_aui_am_lock_rx: directed checkpoint table plus randomized streams checked against
// a word-index reference model of the AM lock rules.
module tb_aui_am_lock_rx;
   localparam int P = 20;
   localparam int LC = 3;
   localparam int UC = 3;
   localparam logic [127:0] AMP = 128'h9A4A26B665B5D9D9_FE8E0C260171F355;
   localparam logic [63:0] AM_A = AMP[127:64];
   localparam logic [63:0] AM_B = AMP[63:0];

   logic        clk = 1'b0, rst = 1'b1;
   logic [63:0] i_data = '0;
   logic        i_valid = 1'b0;
   logic [63:0] o_data;
   logic        o_valid, o_am_lock, o_am_seen, o_am_err;
`ifdef AM_ERR_CNT_EN
   logic [15:0] o_am_err_cnt;
`endif

   aui_am_lock_rx dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
      .o_data(o_data), .o_valid(o_valid), .o_am_lock(o_am_lock),
      .o_am_seen(o_am_seen), .o_am_err(o_am_err)
`ifdef AM_ERR_CNT_EN
      , .o_am_err_cnt(o_am_err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;

   // model: mode 0 search, 1 verify, 2 locked; anchor = valid-word index of the AM that set alignment
   int          m_mode, m_idx, m_anchor, m_good, m_bad;
   logic [63:0] m_prev, m_data;
   logic        m_valid, m_lock, m_seen, m_err;
   logic [15:0] m_errcnt;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_idx = 0; m_anchor = 0; m_good = 0; m_bad = 0;
      m_prev = '0; m_data = '0; m_valid = 0; m_lock = 0; m_seen = 0; m_err = 0; m_errcnt = '0;
   endfunction

   function automatic void model_step(logic [63:0] d, logic v);
      bit match;
      int k;
      m_valid = 0; m_seen = 0; m_err = 0;
      if (v) begin
         match = m_prev == AM_A && d == AM_B;
         k = (m_idx - m_anchor) % (P + 2);
         if (m_mode == 2 && k >= 1 && k <= P) begin
            m_valid = 1; m_data = d;
         end
         if (m_mode == 0) begin
            if (match) begin
               m_anchor = m_idx; m_good = 1; m_mode = LC == 1 ? 2 : 1;
            end
         end else if (k == 0) begin
            if (match) begin
               m_seen = 1;
               if (m_mode == 1) begin
                  m_good++;
                  if (m_good == LC) m_mode = 2;
               end else m_bad = 0;
            end else begin
               m_err = 1;
               if (m_errcnt != 16'hFFFF) m_errcnt++;
               if (m_mode == 1) begin
                  m_mode = 0; m_good = 0;
               end else begin
                  m_bad++;
                  if (m_bad == UC) begin
                     m_mode = 0; m_bad = 0; m_good = 0;
                  end
               end
            end
         end
         m_prev = d;
         m_idx++;
      end
      m_lock = m_mode == 2;
   endfunction

   task automatic drive(input logic [63:0] d, input logic v);
      i_data = d; i_valid = v;
      @(posedge clk);
      model_step(d, v);
      #1;
      chk("o_valid", {63'd0, o_valid}, {63'd0, m_valid});
      chk("o_data", o_data, m_data);
      chk("o_am_lock", {63'd0, o_am_lock}, {63'd0, m_lock});
      chk("o_am_seen", {63'd0, o_am_seen}, {63'd0, m_seen});
      chk("o_am_err", {63'd0, o_am_err}, {63'd0, m_err});
`ifdef AM_ERR_CNT_EN
      chk("o_am_err_cnt", {48'd0, o_am_err_cnt}, {48'd0, m_errcnt});
`endif
   endtask

   // vmode 0: always valid, 1: idle cycle after every word, 2: random idle cycles
   task automatic send_word(input logic [63:0] d, input int vmode);
      drive(d, 1'b1);
      if (vmode == 1 || (vmode == 2 && $urandom_range(3) == 0)) drive(rnd64(), 1'b0);
   endtask

   task automatic send_period(input int npay, input logic [63:0] a, input logic [63:0] b, input int vmode);
      for (int i = 0; i < npay; i++) send_word(rnd64(), vmode);
      send_word(a, vmode);
      send_word(b, vmode);
   endtask

   task automatic do_reset();
      rst = 1'b1; i_valid = 1'b0; i_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      int   n;
      logic lock, valid, seen, err;
   } cp_t;
   cp_t tbl[9];

   initial begin
      logic [63:0] d;
      int ti, n;
      tbl[0] = '{21, 0, 0, 0, 0};
      tbl[1] = '{43, 0, 0, 1, 0};
      tbl[2] = '{64, 0, 0, 0, 0};
      tbl[3] = '{65, 1, 0, 1, 0};
      tbl[4] = '{66, 1, 1, 0, 0};
      tbl[5] = '{85, 1, 1, 0, 0};
      tbl[6] = '{86, 1, 0, 0, 0};
      tbl[7] = '{87, 1, 0, 1, 0};
      tbl[8] = '{88, 1, 1, 0, 0};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst o_valid", {63'd0, o_valid}, 64'd0);
      chk("rst o_data", o_data, 64'd0);
      chk("rst o_am_lock", {63'd0, o_am_lock}, 64'd0);
      chk("rst o_am_seen", {63'd0, o_am_seen}, 64'd0);
      chk("rst o_am_err", {63'd0, o_am_err}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // clean stream with lock-point checkpoints
      ti = 0; n = 0;
      for (int p = 0; p < 5; p++)
         for (int w = 0; w < P + 2; w++) begin
            d = w < P ? rnd64() : w == P ? AM_A : AM_B;
            drive(d, 1'b1);
            if (ti < 9 && tbl[ti].n == n) begin
               chk($sformatf("tbl%0d lock", ti), {63'd0, o_am_lock}, {63'd0, tbl[ti].lock});
               chk($sformatf("tbl%0d valid", ti), {63'd0, o_valid}, {63'd0, tbl[ti].valid});
               chk($sformatf("tbl%0d seen", ti), {63'd0, o_am_seen}, {63'd0, tbl[ti].seen});
               chk($sformatf("tbl%0d err", ti), {63'd0, o_am_err}, {63'd0, tbl[ti].err});
               if (tbl[ti].valid) chk($sformatf("tbl%0d data", ti), o_data, d);
               ti++;
            end
            n++;
         end

      // one corrupted B while locked, then recovery
      send_period(P, AM_A, AM_B ^ 64'h1, 0);
      chk("single bad keeps lock", {63'd0, o_am_lock}, 64'd1);
      send_period(P, AM_A, AM_B, 0);
      // three consecutive bad AMs drop lock
      for (int i = 0; i < 3; i++) send_period(P, AM_A, AM_B ^ 64'h1, 0);
      chk("3 bad drops lock", {63'd0, o_am_lock}, 64'd0);
      // VERIFY with a mis-spaced second AM
      send_period(P, AM_A, AM_B, 0);
      send_period(P + 1, AM_A, AM_B, 0);
      for (int i = 0; i < 3; i++) send_period(P, AM_A, AM_B, 0);
      chk("relock", {63'd0, o_am_lock}, 64'd1);

      // i_valid toggling, then asynchronous reset mid-AM
      do_reset();
      for (int i = 0; i < 4; i++) send_period(P, AM_A, AM_B, 1);
      for (int i = 0; i < P; i++) send_word(rnd64(), 1);
      drive(AM_A, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async rst lock", {63'd0, o_am_lock}, 64'd0);
      chk("async rst valid", {63'd0, o_valid}, 64'd0);
      chk("async rst data", o_data, 64'd0);
      do_reset();

      // randomized streams
      for (int i = 0; i < 40; i++) begin
         int r, np;
         r = $urandom_range(99);
         np = r < 8 ? P - 1 : r < 16 ? P + 1 : P;
         r = $urandom_range(99);
         send_period(np, r < 5 ? AM_A ^ 64'h10 : AM_A, r >= 5 && r < 25 ? AM_B ^ (64'd1 << $urandom_range(63)) : AM_B, $urandom_range(2));
      end

`ifdef AM_ERR_CNT_EN
      do_reset();
      for (int i = 0; i < 4; i++) send_period(P, AM_A, AM_B, 0);
      for (int i = 0; i < 5; i++) begin
         send_period(P, AM_A, AM_B ^ 64'h1, 0);
         if (i % 2 == 1) send_period(P, AM_A, AM_B, 0);
      end
      chk("err_cnt 5", {48'd0, o_am_err_cnt}, 64'd5);
      @(negedge clk);
      force dut.err_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut.err_cnt_q;
      m_errcnt = 16'hFFFE;
      for (int i = 0; i < 3; i++) send_period(P, AM_A, AM_B ^ 64'h1, 0);
      chk("err_cnt sat", {48'd0, o_am_err_cnt}, 64'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
